// File: rtl/tt_um_param_pwm_bank.sv
// ---------------------------------------------------------------------------
// tt_um_param_pwm_bank
//
// Multi-channel PWM tile with a byte-write configuration port. Each channel
// has a double-buffered duty register (shadow written by the host, active
// loaded at the period boundary), so a duty change never cuts a pulse short.
// A global prescaler slows the period counter, and a global mode bit selects
// edge-aligned (sawtooth) or center-aligned (triangle) counting.
//
// Ports:
//   clk      tile clock
//   rst_n    active-low asynchronous reset
//   ena      tile enable; low freezes prescaler, period counter and outputs
//   ui_in    [7] write strobe (asynchronous), [5:3] register select,
//            [2:0] channel address
//   uio_in   write data
//   uo_out   [CHANNELS-1:0] PWM outputs, upper bits driven 0
//   uio_out  always 0
//   uio_oe   always 0 (all uio pins are inputs)
//
// Register map (select value):
//   0  shadow duty of channel 'addr' (ignored when addr >= CHANNELS)
//   1  prescale
//   2  mode (0 edge, 1 center); also restarts the period and loads all
//      shadow duties into the active set
//   3..7 ignored
// ---------------------------------------------------------------------------
module tt_um_param_pwm_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic                strobe_s1;
    logic                strobe_s2;
    logic                strobe_s3;
    logic [WIDTH-1:0]    shadow_duty [CHANNELS];
    logic [WIDTH-1:0]    active_duty [CHANNELS];
    logic [7:0]          prescale;
    logic [7:0]          psc_cnt;
    logic                mode;
    logic [WIDTH-1:0]    cnt;
    logic [WIDTH-1:0]    cnt_next;
    dir_t                dir;
    dir_t                dir_next;
    logic [CHANNELS-1:0] pwm;

    logic                commit;
    logic                tick;
    logic                advance;
    logic                boundary;
    logic [2:0]          reg_sel;
    logic [2:0]          addr;
    logic                unused_bits;

    assign reg_sel     = ui_in[5:3];
    assign addr        = ui_in[2:0];
    assign unused_bits = ui_in[6];

    // Strobe crosses in through two synchronizer flops; the third flop holds
    // the previous synchronized level so a rising edge yields one commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_s1 <= 1'b0;
            strobe_s2 <= 1'b0;
            strobe_s3 <= 1'b0;
        end else begin
            strobe_s1 <= ui_in[7];
            strobe_s2 <= strobe_s1;
            strobe_s3 <= strobe_s2;
        end
    end

    assign commit   = strobe_s2 & ~strobe_s3;
    assign tick     = (psc_cnt == prescale);
    assign advance  = tick & ena;
    assign boundary = advance & (cnt_next == '0);

    // Next counter value. Center mode turns around on reaching either end,
    // so MAX and 0 are each visited once per triangle.
    always_comb begin
        cnt_next = cnt + 1'b1;
        dir_next = DIR_UP;
        if (mode) begin
            if (dir == DIR_DOWN) begin
                cnt_next = cnt - 1'b1;
            end
            dir_next = dir;
            if (cnt_next == MAX) begin
                dir_next = DIR_DOWN;
            end else if (cnt_next == '0) begin
                dir_next = DIR_UP;
            end
        end
    end

    // Timebase and active-duty transfer. A mode write restarts the period
    // and loads the active set at once, even with ena low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode    <= 1'b0;
            cnt     <= '0;
            dir     <= DIR_UP;
            psc_cnt <= 8'd0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                active_duty[ch] <= '0;
            end
        end else if (commit && reg_sel == 3'd2) begin
            mode    <= uio_in[0];
            cnt     <= '0;
            dir     <= DIR_UP;
            psc_cnt <= 8'd0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                active_duty[ch] <= shadow_duty[ch];
            end
        end else if (ena) begin
            psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
            if (advance) begin
                cnt <= cnt_next;
                dir <= dir_next;
            end
            // Shadow is read before this edge's own writes land, so a duty
            // write coinciding with the boundary waits one more period.
            if (boundary) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    active_duty[ch] <= shadow_duty[ch];
                end
            end
        end
    end

    // Host-visible configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale <= 8'd0;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                shadow_duty[ch] <= '0;
            end
        end else if (commit) begin
            if (reg_sel == 3'd1) begin
                prescale <= uio_in;
            end
            if (reg_sel == 3'd0) begin
                for (int ch = 0; ch < CHANNELS; ch++) begin
                    if (addr == 3'(ch)) begin
                        shadow_duty[ch] <= uio_in[WIDTH-1:0];
                    end
                end
            end
        end
    end

    // Registered compare outputs; held while the tile is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= '0;
        end else if (ena) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                pwm[ch] <= (cnt < active_duty[ch]);
            end
        end
    end

    always_comb begin
        uo_out                 = 8'h00;
        uo_out[CHANNELS-1:0]   = pwm;
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_param_pwm_bank.sv
// ---------------------------------------------------------------------------
// tb_tt_um_param_pwm_bank
//
// Self-checking bench for tt_um_param_pwm_bank (CHANNELS=4, WIDTH=4).
// A behavioural model tracks the position inside the PWM period as a phase
// index and derives the counter value arithmetically from it; a compare
// process checks every output on each falling clock edge. Directed scenarios
// pin the model with hand-computed pulse counts, then randomized register
// writes and enable toggling run against the model.
// ---------------------------------------------------------------------------
module tb_tt_um_param_pwm_bank;

    localparam int CH   = 4;
    localparam int MAXV = 15;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    // Behavioural model state
    int       m_shadow [CH];
    int       m_active [CH];
    int       m_prescale;
    int       m_pcount;
    int       m_mode;
    int       m_phase;
    logic [3:0] m_pwm;
    bit       hist [$];

    tt_um_param_pwm_bank #(
        .CHANNELS(CH),
        .WIDTH   (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int period_of(input int mode);
        return (mode != 0) ? 2 * MAXV : MAXV + 1;
    endfunction

    // Counter value at a given phase: sawtooth in edge mode, triangle in
    // center mode.
    function automatic int ctr_of(input int phase, input int mode);
        if (mode == 0) return phase;
        return (phase <= MAXV) ? phase : 2 * MAXV - phase;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: one step per rising edge using the inputs present before it.
    always @(posedge clk or negedge rst_n) begin : model
        bit commit;
        bit tick;
        int sel;
        int adr;
        int data;
        int old_ctr;
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) begin
                m_shadow[c] = 0;
                m_active[c] = 0;
            end
            m_prescale = 0;
            m_pcount   = 0;
            m_mode     = 0;
            m_phase    = 0;
            m_pwm      = 4'b0;
            hist       = '{0, 0, 0};
        end else begin
            // A strobe level sampled three edges ago being low, then high two
            // edges ago, means the synchronized edge arrives now.
            commit  = hist[1] && !hist[2];
            sel     = int'(ui_in[5:3]);
            adr     = int'(ui_in[2:0]);
            data    = int'(uio_in);
            old_ctr = ctr_of(m_phase, m_mode);
            if (ena) begin
                for (int c = 0; c < CH; c++) m_pwm[c] = (old_ctr < m_active[c]);
            end
            tick = (m_pcount == m_prescale);
            if (commit && sel == 2) begin
                m_mode   = data % 2;
                m_phase  = 0;
                m_pcount = 0;
                m_active = m_shadow;
            end else if (ena) begin
                m_pcount = tick ? 0 : (m_pcount + 1) % 256;
                if (tick) begin
                    m_phase = (m_phase + 1) % period_of(m_mode);
                    if (m_phase == 0) m_active = m_shadow;
                end
            end
            if (commit && sel == 0 && adr < CH) m_shadow[adr] = data % 16;
            if (commit && sel == 1) m_prescale = data;
            hist.push_front(ui_in[7]);
            void'(hist.pop_back());
        end
    end

    // Continuous comparison against the model away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("uo_out vs model", uo_out, {4'b0, m_pwm});
            checkOutput("uio_out", uio_out, 32'h0);
            checkOutput("uio_oe", uio_oe, 32'h0);
        end
    end

    // One register write: data and select settle a cycle before the strobe
    // rises, the strobe stays high past the commit, then drops.
    task automatic applyStimulus(input int sel, input int adr, input int data);
        @(negedge clk);
        ui_in  = {2'b00, 3'(sel), 3'(adr)};
        uio_in = 8'(data);
        @(negedge clk);
        ui_in[7] = 1'b1;
        repeat (5) @(negedge clk);
        ui_in[7] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic countHigh(input int bit_idx, input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (uo_out[bit_idx]) cnt++;
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        int cnt;
        int waited;
        int nonzero;
        int r;
        int sel;
        int data;

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        @(negedge clk);
        check_en = 1'b1;
        checkOutput("reset uo_out", uo_out, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post-reset uo_out", uo_out, 32'h0);

        // Edge mode, ch0 duty 4, prescale 0: 4 of every 16 cycles
        applyStimulus(0, 0, 4);
        applyStimulus(2, 0, 0);
        countHigh(0, 16, cnt);
        checkOutput("edge duty4 ch0 high count", cnt, 4);
        nonzero = 0;
        repeat (16) begin
            @(negedge clk);
            if (uo_out[7:1] != 7'd0) nonzero++;
        end
        checkOutput("edge unused channels high", nonzero, 0);

        // Prescale 2: 48-cycle period, 12 high
        applyStimulus(1, 0, 2);
        countHigh(0, 48, cnt);
        checkOutput("prescale2 ch0 high count", cnt, 12);

        // Center mode, ch1 duty 4, prescale 0: 7 of every 30 cycles
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 4);
        applyStimulus(2, 0, 1);
        countHigh(1, 30, cnt);
        checkOutput("center duty4 ch1 high count", cnt, 7);

        // Out-of-range channel and unused select leave everything alone
        applyStimulus(0, 6, 15);
        applyStimulus(5, 0, 8'hff);
        countHigh(1, 30, cnt);
        checkOutput("ignored writes ch1 high count", cnt, 7);
        countHigh(0, 30, cnt);
        checkOutput("ignored writes ch0 high count", cnt, 7);

        // Back to edge mode, then raise ch0 duty mid-period
        applyStimulus(2, 0, 0);
        applyStimulus(0, 0, 12);
        repeat (20) @(negedge clk);
        countHigh(0, 16, cnt);
        checkOutput("edge duty12 ch0 high count", cnt, 12);

        // Asynchronous reset while ch0 is high
        waited = 0;
        while (uo_out[0] !== 1'b1 && waited < 32) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ch0 high before async reset", uo_out[0], 1);
        #3 rst_n = 1'b0;
        #1 checkOutput("async reset uo_out", uo_out, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        nonzero = 0;
        repeat (40) begin
            @(negedge clk);
            if (uo_out != 8'd0) nonzero++;
        end
        checkOutput("outputs low after reset", nonzero, 0);

        // Randomized writes and enable toggling against the model
        for (int i = 0; i < 150; i++) begin
            ena = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 5)      sel = 0;
            else if (r < 7) sel = 1;
            else if (r < 8) sel = 2;
            else            sel = $urandom_range(3, 7);
            data = $urandom_range(0, 255);
            if (sel == 1) data = $urandom_range(0, 3);
            applyStimulus(sel, $urandom_range(0, 7), data);
            repeat ($urandom_range(0, 20)) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) ena = ~ena;
            end
        end
        ena = 1'b1;
        repeat (40) @(negedge clk);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
